// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-side multiply/divide sequencer: op codes,
// FSM encodings and the stall/start level names used by muldiv_ctrl.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic Stop     = 1'b1;
  localparam logic NoStop   = 1'b0;
  localparam logic MulStart = 1'b1;
  localparam logic MulStop  = 1'b0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_fastpath.sv
// Trivial-operand detect: zero multiplicand/multiplier or zero divisor can be
// answered without the iterative engine.
module muldiv_fastpath
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   src1,
  input  logic [DATA_W-1:0]   src2,
  output logic                hit,
  output logic [2*DATA_W-1:0] result
);

  always_comb begin
    hit    = 1'b0;
    result = '0;
    if (is_div_op(op)) begin
      // Divide by zero: remainder is the dividend, quotient all ones.
      if (src2 == '0) begin
        hit    = 1'b1;
        result = {src1, {DATA_W{1'b1}}};
      end
    end else if (src1 == '0 || src2 == '0) begin
      hit = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Single FSM owning the shared mul/div engine: start/annul handshake, EX stall,
// one-shot HI/LO write held until the pipe advances. MULDIV_FASTPATH_EN enables
// the zero-operand bypass.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [1:0]          req_op,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                flush,
  input  logic                pipe_stall,
  output logic                eng_start,
  output logic                eng_annul,
  output logic                eng_signed,
  output logic                eng_is_div,
  output logic [DATA_W-1:0]   eng_op1,
  output logic [DATA_W-1:0]   eng_op2,
  input  logic [2*DATA_W-1:0] eng_result,
  input  logic                eng_ready,
  output logic                stallreq,
  output logic                hilo_we,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);

  logic [1:0]          state;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   src1_q, src2_q;
  logic [2*DATA_W-1:0] res_q;
  logic [CNT_W-1:0]    cnt;
  logic                busy, timeout;
  logic                fp_hit;
  logic [2*DATA_W-1:0] fp_res;

`ifdef MULDIV_FASTPATH_EN
  muldiv_fastpath #(.DATA_W(DATA_W)) u_fastpath (
    .op     (req_op),
    .src1   (req_src1),
    .src2   (req_src2),
    .hit    (fp_hit),
    .result (fp_res)
  );
`else
  assign fp_hit = 1'b0;
  assign fp_res = '0;
`endif

  assign busy    = (state == ST_BUSY);
  // Ready on the last allowed cycle still wins over the abort.
  assign timeout = busy && !eng_ready && (cnt == CNT_LAST);

  assign eng_start  = busy ? (is_div_op(op_q) ? DivStart : MulStart)
                           : (is_div_op(op_q) ? DivStop  : MulStop);
  assign eng_signed = busy && is_signed_op(op_q);
  assign eng_is_div = busy && is_div_op(op_q);
  assign eng_op1    = src1_q;
  assign eng_op2    = src2_q;
  assign hi_o       = res_q[2*DATA_W-1:DATA_W];
  assign lo_o       = res_q[DATA_W-1:0];

  always_comb begin
    stallreq    = NoStop;
    hilo_we     = 1'b0;
    eng_annul   = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      ST_IDLE: stallreq = req_valid ? Stop : NoStop;
      ST_BUSY: begin
        stallreq = Stop;
        if (flush) begin
          eng_annul = 1'b1;
        end else if (timeout) begin
          eng_annul   = 1'b1;
          timeout_err = 1'b1;
        end
      end
      ST_DONE: hilo_we = ~flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      res_q  <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
            cnt    <= '0;
            if (fp_hit) begin
              res_q <= fp_res;
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (eng_ready) begin
            res_q <= eng_result;
            state <= ST_DONE;
          end else if (timeout) begin
            res_q <= '0;
            state <= ST_DONE;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // MEM only latches HI/LO when the pipe advances.
          if (flush || !pipe_stall) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a latency-programmable engine model and
// an expected-result queue popped whenever the HI/LO write appears.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = '0, req_src2 = '0;
  logic        flush = 1'b0, pipe_stall = 1'b0;
  logic        eng_start, eng_annul, eng_signed, eng_is_div;
  logic [31:0] eng_op1, eng_op2;
  logic [63:0] eng_result;
  logic        eng_ready;
  logic        stallreq, hilo_we, timeout_err;
  logic [31:0] hi_o, lo_o;

  muldiv_ctrl #(.DATA_W(32), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush), .pipe_stall(pipe_stall),
    .eng_start(eng_start), .eng_annul(eng_annul), .eng_signed(eng_signed),
    .eng_is_div(eng_is_div), .eng_op1(eng_op1), .eng_op2(eng_op2),
    .eng_result(eng_result), .eng_ready(eng_ready), .stallreq(stallreq),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Engine model: ready after eng_lat cycles of start, held until start drops.
  int   eng_lat = 32;
  int   ecnt = 0;
  logic ready_force = 1'b0;

  always_ff @(posedge clk) begin
    if (!eng_start) ecnt <= 0;
    else            ecnt <= ecnt + 1;
  end

  function automatic logic [63:0] eng_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg, input logic dv);
    logic signed [63:0] sa, sb;
    logic signed [31:0] x, y;
    if (dv) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sg) begin
        x = a; y = b;
        return {32'(x % y), 32'(x / y)};
      end
      return {a % b, a / b};
    end
    if (sg) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  assign eng_ready  = (eng_start && (ecnt >= eng_lat - 1)) || ready_force;
  assign eng_result = eng_calc(eng_op1, eng_op2, eng_signed, eng_is_div);

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];
  int n_stall, n_start, n_to, n_annul;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, {59'd0, eng_start, hilo_we, stallreq, eng_annul, timeout_err}, 64'd0);
    @(posedge clk); #1;
  endtask

  // Issue one request, hold it while stalled, check the HI/LO write and release.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input logic [63:0] exp,
                        input int exp_stall, input int exp_start, input int exp_to);
    logic [63:0] want;
    int guard, we;
    logic seen, last;
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    pipe_stall = (hold > 0);
    sb.push_back(exp);
    n_stall = 0; n_start = 0; n_to = 0; n_annul = 0; guard = 0; seen = 1'b0;
    @(negedge clk);
    while (!hilo_we && guard < 200) begin
      n_stall += int'(stallreq);
      n_start += int'(eng_start);
      n_to    += int'(timeout_err);
      n_annul += int'(eng_annul);
      if (eng_start && !seen) begin
        seen = 1'b1;
        chk({tag, "_ops"}, {eng_op1, eng_op2}, {a, b});
        chk({tag, "_kind"}, {62'd0, eng_signed, eng_is_div},
            {62'd0, (op == MD_MULT) || (op == MD_DIV), op[1]});
      end
      guard++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk({tag, "_we"}, {63'd0, hilo_we}, 64'd1);
    chk({tag, "_stallcyc"}, 64'(n_stall), 64'(exp_stall));
    chk({tag, "_startcyc"}, 64'(n_start), 64'(exp_start));
    chk({tag, "_timeout"}, 64'(n_to), 64'(exp_to));
    chk({tag, "_annul"}, 64'(n_annul), 64'(exp_to));
    want = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    we = 0;
    forever begin
      we++;
      chk({tag, "_hilo"}, {hi_o, lo_o}, want);
      chk({tag, "_donectl"}, {60'd0, stallreq, eng_start, timeout_err, eng_annul}, 64'd0);
      last = !pipe_stall;
      @(posedge clk); #1;
      if (last || we > 8) break;
      if (we >= hold) pipe_stall = 1'b0;
      @(negedge clk);
      if (!hilo_we) break;
    end
    req_valid = 1'b0;
    pipe_stall = 1'b0;
    chk({tag, "_wecyc"}, 64'(we), 64'(hold + 1));
  endtask

  initial begin
    int n, guard;
    logic [63:0] want;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {57'd0, eng_start, eng_annul, eng_signed, eng_is_div, stallreq, hilo_we, timeout_err}, 64'd0);
    chk("rst_ops", {eng_op1, eng_op2}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_chk("post_rst");

    // Signed multiply, engine done after 32 cycles
    run_op("mult", MD_MULT, -32'sd3, 32'd5, 0, 64'hFFFF_FFFF_FFFF_FFF1, 33, 32, 0);
    idle_chk("mult_idle");

    // Unsigned divide held three cycles at DONE
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 3, {32'd2, 32'd14}, 33, 32, 0);
    idle_chk("divu_idle");

    // Flush at BUSY cycle 5
    req_valid = 1'b1; req_op = MD_DIV; req_src1 = 32'd20; req_src2 = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("fl_annul", {61'd0, eng_annul, eng_start, hilo_we}, {61'd0, 3'b110});
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("fl_after", {61'd0, eng_annul, eng_start, stallreq}, 64'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      @(negedge clk);
      n += int'(hilo_we) + int'(eng_start);
    end
    chk("fl_quiet", 64'(n), 64'd0);
    @(posedge clk); #1;

    // Engine never ready: abort on the 64th BUSY cycle with a zero result
    eng_lat = 100000;
    run_op("tmo", MD_MULT, 32'd7, 32'd7, 0, 64'd0, 65, 64, 1);
    eng_lat = 32;
    idle_chk("tmo_idle");

    // Back-to-back requests
    run_op("b2b_mul", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, {32'd1, 32'hFFFF_FFFE}, 33, 32, 0);
    run_op("b2b_div", MD_DIVU, 32'd9, 32'd2, 0, {32'd1, 32'd4}, 33, 32, 0);
    idle_chk("b2b_idle");

    // Zero-operand requests: bypass when the fast path is built in
`ifdef MULDIV_FASTPATH_EN
    run_op("div0", MD_DIV, 32'd8, 32'd0, 0, {32'd8, 32'hFFFF_FFFF}, 1, 0, 0);
    run_op("mul0", MD_MULTU, 32'd0, 32'd5, 0, 64'd0, 1, 0, 0);
`else
    run_op("div0", MD_DIV, 32'd8, 32'd0, 0, {32'd8, 32'hFFFF_FFFF}, 33, 32, 0);
    run_op("mul0", MD_MULTU, 32'd0, 32'd5, 0, 64'd0, 33, 32, 0);
`endif
    idle_chk("zero_idle");

    // Request with flush in IDLE is dropped
    req_valid = 1'b1; req_op = MD_MULT; req_src1 = 32'd2; req_src2 = 32'd3; flush = 1'b1;
    @(negedge clk);
    chk("idlefl_stall", {63'd0, stallreq}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    idle_chk("idlefl_ignored");

    // Stray ready while idle is ignored
    ready_force = 1'b1;
    @(posedge clk); #1;
    ready_force = 1'b0;
    idle_chk("stray_ready");

    // Flush while held at DONE suppresses the write
    eng_lat = 4;
    req_valid = 1'b1; req_op = MD_MULTU; req_src1 = 32'd3; req_src2 = 32'd4; pipe_stall = 1'b1;
    sb.push_back({32'd0, 32'd12});
    guard = 0;
    @(negedge clk);
    while (!hilo_we && guard < 50) begin
      guard++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    want = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    chk("dfl_we", {63'd0, hilo_we}, 64'd1);
    chk("dfl_hilo", {hi_o, lo_o}, want);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("dfl_suppress", {62'd0, hilo_we, stallreq}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0; pipe_stall = 1'b0;
    idle_chk("dfl_idle");
    eng_lat = 32;

    // Reset in the middle of BUSY
    req_valid = 1'b1; req_op = MD_DIVU; req_src1 = 32'd50; req_src2 = 32'd5;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_ctl", {61'd0, eng_start, stallreq, hilo_we}, 64'd0);
    chk("midrst_ops", {eng_op1, eng_op2}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_chk("midrst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
